// File: rtl/rr_sample_arbiter_if.sv
// Bus bundle for rr_sample_arbiter: requester side (req/data_in/gnt) and
// consumer side (out_* valid/ready handshake).
interface rr_sample_arbiter_if #(
    parameter int N = 4,
    parameter int W = 1
) ();
    localparam int ID_W = $clog2(N);

    logic [N-1:0]    req;
    logic [N*W-1:0]  data_in;
    logic [N-1:0]    gnt;
    logic [W-1:0]    out_data;
    logic [ID_W-1:0] out_id;
    logic            out_valid;
    logic            out_ready;

    // Requesters plus consumer: drive requests and data, accept samples.
    modport master (
        output req, data_in, out_ready,
        input  gnt, out_data, out_id, out_valid
    );

    // Arbiter side.
    modport slave (
        input  req, data_in, out_ready,
        output gnt, out_data, out_id, out_valid
    );
endinterface

// File: rtl/rr_sample_arbiter.sv
// Round-robin arbiter sharing one registered capture stage among N requesters.
// IDLE -> GRANT (one cycle, gnt asserted) -> HOLD (sample presented until
// taken); a taken sample may chain straight into the next GRANT.
module rr_sample_arbiter #(
    parameter int N = 4,
    parameter int W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_sample_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        HOLD
    } state_t;

    state_t          state, state_nx;
    logic [ID_W-1:0] sel, sel_nx;
    logic [ID_W-1:0] last, last_nx;
    logic [N-1:0]    gnt_q, gnt_nx;
    logic [W-1:0]    data_q, data_nx;
    logic [ID_W-1:0] id_q, id_nx;
    logic            valid_q, valid_nx;

    logic [ID_W-1:0] pick;
    logic            hi_found;
    logic            lo_found;
    logic [N-1:0]    pick_onehot;
    logic [W-1:0]    cap_data;

    assign bus.gnt       = gnt_q;
    assign bus.out_data  = data_q;
    assign bus.out_id    = id_q;
    assign bus.out_valid = valid_q;

    // Round-robin winner: first requester above the last winner, otherwise
    // the lowest requester at or below it (the wrapped part of the scan).
    always_comb begin
        pick     = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!hi_found && bus.req[i] && (ID_W'(i) > last)) begin
                hi_found = 1'b1;
                pick     = ID_W'(i);
            end
        end
        if (!hi_found) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!lo_found && bus.req[i]) begin
                    lo_found = 1'b1;
                    pick     = ID_W'(i);
                end
            end
        end
    end

    // One-hot grant vector for the winner and the granted requester's data.
    always_comb begin
        pick_onehot = '0;
        cap_data    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pick_onehot[i] = (ID_W'(i) == pick);
            if (ID_W'(i) == sel) begin
                cap_data = bus.data_in[i*W +: W];
            end
        end
    end

    // Next-state and next-output logic for the grant/capture/hold sequence.
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        last_nx  = last;
        gnt_nx   = '0;
        data_nx  = data_q;
        id_nx    = id_q;
        valid_nx = valid_q;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    sel_nx   = pick;
                    gnt_nx   = pick_onehot;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                // Capture is committed even if the request dropped meanwhile.
                data_nx  = cap_data;
                id_nx    = sel;
                valid_nx = 1'b1;
                last_nx  = sel;
                state_nx = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    valid_nx = 1'b0;
                    if (|bus.req) begin
                        sel_nx   = pick;
                        gnt_nx   = pick_onehot;
                        state_nx = GRANT;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears the held sample immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel     <= '0;
            last    <= ID_W'(N - 1);
            gnt_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            sel     <= sel_nx;
            last    <= last_nx;
            gnt_q   <= gnt_nx;
            data_q  <= data_nx;
            id_q    <= id_nx;
            valid_q <= valid_nx;
        end
    end
endmodule

// File: tb/tb_rr_sample_arbiter.sv
// Scoreboard bench for rr_sample_arbiter: a transaction-level model predicts
// each grant and each captured sample; a negedge monitor compares them.
module tb_rr_sample_arbiter;
    localparam int N    = 4;
    localparam int W    = 1;
    localparam int ID_W = $clog2(N);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [W-1:0]    data;
    } sample_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rr_sample_arbiter_if #(.N(N), .W(W)) bus ();

    rr_sample_arbiter #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sample_t      sq[$];
    logic [N-1:0] gq[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    // Reference model state: last winner, grant outstanding, sample held.
    int m_last;
    int m_sel;
    bit m_granting;
    bit m_pending;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    function automatic int ref_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last     = N - 1;
        m_sel      = 0;
        m_granting = 1'b0;
        m_pending  = 1'b0;
    endtask

    // Predicts what the coming clock edge does, given the inputs now applied.
    task automatic model_step();
        sample_t        s;
        logic [N*W-1:0] sh;
        if (m_granting) begin
            sh         = bus.data_in >> (m_sel * W);
            s.id       = ID_W'(m_sel);
            s.data     = sh[W-1:0];
            sq.push_back(s);
            m_last     = m_sel;
            m_pending  = 1'b1;
            m_granting = 1'b0;
        end else if (!m_pending || bus.out_ready) begin
            m_pending = 1'b0;
            if (bus.req != '0) begin
                m_sel      = ref_pick(bus.req, m_last);
                gq.push_back(N'(1) << m_sel);
                m_granting = 1'b1;
            end
        end
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic rdy);
        @(posedge clk);
        #2;
        bus.req       = r;
        bus.data_in   = d;
        bus.out_ready = rdy;
        model_step();
    endtask

    // Monitor: compare every grant pulse and every presented sample.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.gnt != '0) begin
                if (gq.size() == 0) fail_now("gnt_unexpected");
                else chk("gnt", 32'(bus.gnt), 32'(gq.pop_front()));
            end
            if (bus.out_valid) begin
                chk("gnt_in_hold", 32'(bus.gnt), 32'd0);
                if (sq.size() == 0) begin
                    fail_now("sample_unexpected");
                end else begin
                    chk("out_id", 32'(bus.out_id), 32'(sq[0].id));
                    chk("out_data", 32'(bus.out_data), 32'(sq[0].data));
                    if (bus.out_ready) void'(sq.pop_front());
                end
            end
        end
    end

    initial begin
        bus.req       = '0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        #23 rst_n = 1'b1;

        // Single requester 2 with data 1.
        drive(4'b0100, 4'b0100, 1'b1);
        drive(4'b0000, 4'b0100, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1);

        // Asynchronous reset while a sample is held.
        drive(4'b0010, 4'b0010, 1'b0);
        drive(4'b0000, 4'b0010, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0);
        #1;
        chk("valid_before_reset", 32'(bus.out_valid), 32'd1);
        rst_n   = 1'b0;
        bus.req = '0;
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_id", 32'(bus.out_id), 32'd0);
        sq.delete();
        gq.delete();
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Fairness: all requesting, data_in = {1,0,1,0}.
        for (int i = 0; i < 10; i++) drive(4'b1111, 4'b1010, 1'b1);
        for (int i = 0; i < 3; i++) drive(4'b0000, 4'b0000, 1'b1);

        // Backpressure with new requests pending during hold.
        drive(4'b0001, 4'b0001, 1'b0);
        for (int i = 0; i < 6; i++) drive(4'b0011, 4'b0011, 1'b0);
        for (int i = 0; i < 3; i++) drive(4'b0000, 4'b0010, 1'b1);
        for (int i = 0; i < 2; i++) drive(4'b0000, 4'b0000, 1'b1);

        // Pointer wrap: 3, then 0, then 3.
        drive(4'b1000, 4'b1001, 1'b1);
        for (int i = 0; i < 4; i++) drive(4'b1001, 4'b1001, 1'b1);
        for (int i = 0; i < 3; i++) drive(4'b0000, 4'b0000, 1'b1);

        // Request dropped during the grant cycle is still captured.
        drive(4'b0010, 4'b0010, 1'b1);
        drive(4'b0000, 4'b0010, 1'b1);
        for (int i = 0; i < 3; i++) drive(4'b0000, 4'b0000, 1'b1);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0]   r;
            logic [N*W-1:0] d;
            r = N'($urandom) & N'($urandom);
            d = (N*W)'($urandom);
            drive(r, d, ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 5; i++) drive(4'b0000, 4'b0000, 1'b1);

        #4;
        chk("grants_outstanding", 32'(gq.size()), 32'd0);
        chk("samples_outstanding", 32'(sq.size()), 32'd0);
        chk("valid_at_end", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
